hazard_idex: RTL
================

HAZARD_IDEX -- requirements
Module: hazard_idex

Interface
REQ-001 Parameter: DATA_W, 32, width of the data, immediate and PC+4 fields.
REQ-002 Parameter: CNT_W, 16, width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ExtendSel  input  1 each  decode-stage control bits from the pipelined control unit.
REQ-006 id_ALUOp  input  2  decode-stage ALU operation class.
REQ-007 id_rs_data, id_rt_data, id_imm, id_pc4  input  DATA_W each  register-file read data, extended immediate, PC+4.
REQ-008 id_rs, id_rt, id_rd  input  5 each  decode-stage register numbers.
REQ-009 flush  input  1  taken branch/jump resolved downstream; squashes the decode-stage instruction.
REQ-010 ex_* (one per id_* input above)  output  same widths  registered ID/EX copies.
REQ-011 ex_valid  output  1  ID/EX slot holds a real instruction (0 = bubble).
REQ-012 en_reg  output  1  combinational; 0 freezes PC, IF/ID and forces the control unit to zeros.
REQ-013 stall_count  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-014 Load-use hazard (hz) SHALL be: ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
REQ-015 en_reg SHALL be 0 when hz & !flush, else 1; no registered delay.
REQ-016 Per rising edge, priority: flush > hz > normal load.
REQ-017 flush: all ex_ control bits, ex_ALUOp, and ex_valid SHALL become 0; data/register fields SHALL hold their previous values.
REQ-018 hz (no flush): same bubble as REQ-017; stall_count SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-019 Normal: every ex_ field SHALL capture its id_ counterpart bit-exactly (x inputs pass through); ex_valid SHALL become 1.
REQ-020 Latency: id_ to ex_ SHALL be exactly one clock; en_reg SHALL react in the same cycle as the hazard condition.
REQ-021 A single load SHALL cause at most one stall cycle: after the bubble, ex_MemRead = 0 so hz deasserts.
REQ-022 Stall with flush in the same cycle: flush wins, en_reg = 1, stall_count unchanged.
REQ-023 ex_rt = 0 SHALL never cause a stall, even with ex_MemRead = 1.
REQ-024 Bubble (ex_valid = 0) with stale ex_MemRead SHALL NOT cause a stall; bubble control bits are 0 anyway.
REQ-025 No state machine beyond the ID/EX register and counter; the block holds no other state.

Reset
REQ-026 rst = 0 SHALL immediately, without clk, force all ex_ outputs, ex_valid and stall_count to 0.
REQ-027 en_reg SHALL be 1 during reset (ex_valid = 0 inhibits hz).
REQ-028 Reset mid-stall SHALL abort the stall; the first edge after rst rises SHALL load id_ inputs normally.
REQ-029 Reset release SHALL not require alignment to clk; the first capture is the first rising edge with rst = 1.

Verification
REQ-030 Reset: rst = 0 with random inputs -> all ex_ = 0, ex_valid = 0, stall_count = 0, en_reg = 1; rst = 1, then R-type id_ (RegDst = 1, RegWrite = 1, ALUOp = 10, rs = 8, rt = 9, rd = 10) -> next edge ex_ fields equal, ex_valid = 1.
REQ-031 Load-use: LW with rt = 9 in EX, id_rs = 9 -> en_reg = 0 that cycle, next edge ex_valid = 0, stall_count = 1; following cycle en_reg = 1 and the dependent instruction enters EX.
REQ-032 No hazard: LW with rt = 0 in EX, id_rs = 0 -> en_reg = 1, no bubble, stall_count unchanged.
REQ-033 Flush vs stall: LW with rt = 5 in EX, id_rt = 5, flush = 1 -> en_reg = 1, next edge ex_valid = 0, ex_RegWrite = 0, stall_count unchanged.
REQ-034 Saturation: preload with 65534 stalls, then apply 3 more hazards -> stall_count = 65535 and holds.
REQ-035 Async reset mid-stall: assert rst = 0 between edges while en_reg = 0 -> outputs clear at once, en_reg = 1.

Source files
------------

// File: rtl/hazard_idex_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_idex_if
//  Description : Bundle between the decode stage / control unit and the
//                ID/EX pipeline register with load-use hazard detection.
//                Carries the decode-stage instruction fields (id_*), the
//                downstream flush request, the registered EX-stage copies
//                (ex_*), the slot-valid flag, the pipeline enable and the
//                stall counter.
//                  master : decode side, drives id_* and flush
//                  slave  : ID/EX register, drives ex_*, en_reg, stall_count
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_idex_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    // Decode-stage control bits
    logic              id_RegDst;
    logic              id_ALUSrc;
    logic              id_MemtoReg;
    logic              id_RegWrite;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_Branch;
    logic              id_Jump;
    logic              id_ExtendSel;
    logic [1:0]        id_ALUOp;
    // Decode-stage data and register numbers
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    // Taken branch/jump resolved downstream
    logic              flush;

    // Registered EX-stage copies
    logic              ex_RegDst;
    logic              ex_ALUSrc;
    logic              ex_MemtoReg;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_Branch;
    logic              ex_Jump;
    logic              ex_ExtendSel;
    logic [1:0]        ex_ALUOp;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic              ex_valid;
    // Pipeline enable and stall statistics
    logic              en_reg;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
               id_MemWrite, id_Branch, id_Jump, id_ExtendSel, id_ALUOp,
               id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd,
               flush,
        input  ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
               ex_MemWrite, ex_Branch, ex_Jump, ex_ExtendSel, ex_ALUOp,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
               ex_valid, en_reg, stall_count
    );

    modport slave (
        input  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
               id_MemWrite, id_Branch, id_Jump, id_ExtendSel, id_ALUOp,
               id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd,
               flush,
        output ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
               ex_MemWrite, ex_Branch, ex_Jump, ex_ExtendSel, ex_ALUOp,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
               ex_valid, en_reg, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_idex.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_idex
//  Description : ID/EX pipeline register with load-use hazard detection.
//                A load sitting in EX whose destination (rt, non-zero) is a
//                source of the decode-stage instruction drops en_reg in the
//                same cycle (freezing PC and IF/ID) and inserts a bubble on
//                the next edge.  A downstream flush overrides the stall and
//                also inserts a bubble.  Bubbles zero the control bits and
//                ALUOp but leave the data/register fields untouched.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                bus  - hazard_idex_if.slave (id_* in, flush in, ex_* out,
//                       ex_valid, en_reg, stall_count out)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_idex #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hazard_idex_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              r_RegDst;
    logic              r_ALUSrc;
    logic              r_MemtoReg;
    logic              r_RegWrite;
    logic              r_MemRead;
    logic              r_MemWrite;
    logic              r_Branch;
    logic              r_Jump;
    logic              r_ExtendSel;
    logic [1:0]        r_ALUOp;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_rt_match;
    logic              w_hz;

    // Hazard is evaluated purely from the current EX slot and the decode
    // operands.  Gating with r_valid keeps bubbles from ever stalling, and
    // because a bubble clears MemRead a single load can stall at most once.
    assign w_rt_match = (r_rt == bus.id_rs) || (r_rt == bus.id_rt);
    assign w_hz       = r_valid && r_MemRead && (r_rt != 5'd0) && w_rt_match;

    // Flush discards the decode instruction anyway, so no freeze is needed.
    assign bus.en_reg = !(w_hz && !bus.flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_RegDst      <= 1'b0;
            r_ALUSrc      <= 1'b0;
            r_MemtoReg    <= 1'b0;
            r_RegWrite    <= 1'b0;
            r_MemRead     <= 1'b0;
            r_MemWrite    <= 1'b0;
            r_Branch      <= 1'b0;
            r_Jump        <= 1'b0;
            r_ExtendSel   <= 1'b0;
            r_ALUOp       <= 2'b00;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_pc4         <= '0;
            r_rs          <= 5'd0;
            r_rt          <= 5'd0;
            r_rd          <= 5'd0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
        end else if (bus.flush || w_hz) begin
            // Bubble: kill control, keep data fields as they were.
            r_RegDst    <= 1'b0;
            r_ALUSrc    <= 1'b0;
            r_MemtoReg  <= 1'b0;
            r_RegWrite  <= 1'b0;
            r_MemRead   <= 1'b0;
            r_MemWrite  <= 1'b0;
            r_Branch    <= 1'b0;
            r_Jump      <= 1'b0;
            r_ExtendSel <= 1'b0;
            r_ALUOp     <= 2'b00;
            r_valid     <= 1'b0;
            // Only genuine stalls are counted; flush has priority.
            if (!bus.flush && (r_stall_count != c_CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end else begin
            r_RegDst    <= bus.id_RegDst;
            r_ALUSrc    <= bus.id_ALUSrc;
            r_MemtoReg  <= bus.id_MemtoReg;
            r_RegWrite  <= bus.id_RegWrite;
            r_MemRead   <= bus.id_MemRead;
            r_MemWrite  <= bus.id_MemWrite;
            r_Branch    <= bus.id_Branch;
            r_Jump      <= bus.id_Jump;
            r_ExtendSel <= bus.id_ExtendSel;
            r_ALUOp     <= bus.id_ALUOp;
            r_rs_data   <= bus.id_rs_data;
            r_rt_data   <= bus.id_rt_data;
            r_imm       <= bus.id_imm;
            r_pc4       <= bus.id_pc4;
            r_rs        <= bus.id_rs;
            r_rt        <= bus.id_rt;
            r_rd        <= bus.id_rd;
            r_valid     <= 1'b1;
        end
    end

    assign bus.ex_RegDst    = r_RegDst;
    assign bus.ex_ALUSrc    = r_ALUSrc;
    assign bus.ex_MemtoReg  = r_MemtoReg;
    assign bus.ex_RegWrite  = r_RegWrite;
    assign bus.ex_MemRead   = r_MemRead;
    assign bus.ex_MemWrite  = r_MemWrite;
    assign bus.ex_Branch    = r_Branch;
    assign bus.ex_Jump      = r_Jump;
    assign bus.ex_ExtendSel = r_ExtendSel;
    assign bus.ex_ALUOp     = r_ALUOp;
    assign bus.ex_rs_data   = r_rs_data;
    assign bus.ex_rt_data   = r_rt_data;
    assign bus.ex_imm       = r_imm;
    assign bus.ex_pc4       = r_pc4;
    assign bus.ex_rs        = r_rs;
    assign bus.ex_rt        = r_rt;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_valid     = r_valid;
    assign bus.stall_count  = r_stall_count;

endmodule
`default_nettype wire
